// File: rtl/package_settings.sv
// ---------------------------------------------------------------------------
// package_settings
// Settings shared by the trapezoidal filter chain and its controllers.
//   SIZE_ADC_DATA : width of ADC samples and of the filter output data.
// ---------------------------------------------------------------------------
package package_settings;

    localparam int SIZE_ADC_DATA = 12;

endpackage : package_settings

// File: rtl/v3_filter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// v3_filter_ctrl_parameters
// Types and default settings for the v3 filter run controller.
//   ctrl_state_t           : run-controller FSM states
//   DEF_*                  : default values of the controller parameters
//   CLEAR_CYCLES           : length of the filter clear pulse
//   max_of3()              : helper used to size the shared phase counter
// ---------------------------------------------------------------------------
package v3_filter_ctrl_parameters;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ARMED  = 3'd3,
        ST_PEAK   = 3'd4,
        ST_DEAD   = 3'd5
    } ctrl_state_t;

    localparam int DEF_SETTLE_CYCLES = 32;
    localparam int DEF_PEAK_WINDOW   = 16;
    localparam int DEF_DEAD_CYCLES   = 8;
    localparam int DEF_TS_WIDTH      = 32;
    localparam int DEF_CNT_WIDTH     = 8;

    localparam int CLEAR_CYCLES = 2;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : v3_filter_ctrl_parameters

// File: rtl/v3_filter_ctrl_peak.sv
// ---------------------------------------------------------------------------
// v3_filter_ctrl_peak
// Peak search over a fixed window of filter samples. The window is opened by
// i_start (trigger sample) and advanced by i_sample for every following
// sample. o_amp/o_time already include the sample currently on i_data, so
// the caller can issue the event on the same edge as the final compare.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load trigger sample, window count = 1
//   i_sample       : compare i_data against the running maximum
//   i_data         : filter output sample
//   i_time         : timestamp of the current sample
//   o_done         : current sample is the last one of the window
//   o_amp, o_time  : window maximum and its timestamp, current sample included
// ---------------------------------------------------------------------------
module v3_filter_ctrl_peak #(
    parameter int DATA_W      = 12,
    parameter int TS_W        = 32,
    parameter int PEAK_WINDOW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_sample,
    input  logic [DATA_W-1:0] i_data,
    input  logic [TS_W-1:0]   i_time,
    output logic              o_done,
    output logic [DATA_W-1:0] o_amp,
    output logic [TS_W-1:0]   o_time
);

    localparam int WIN_W = $clog2(PEAK_WINDOW);

    logic [DATA_W-1:0] r_amp;
    logic [TS_W-1:0]   r_time;
    logic [WIN_W-1:0]  r_win_cnt;
    logic              w_new_max;

    // Strict compare: on a tie the earlier sample stays the maximum.
    assign w_new_max = (i_data > r_amp);

    // Running maximum and window position.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_amp     <= '0;
            r_time    <= '0;
            r_win_cnt <= '0;
        end else if (i_start) begin
            r_amp     <= i_data;
            r_time    <= i_time;
            r_win_cnt <= WIN_W'(1);
        end else if (i_sample) begin
            if (w_new_max) begin
                r_amp  <= i_data;
                r_time <= i_time;
            end
            r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
    end

    assign o_done = (r_win_cnt == WIN_W'(PEAK_WINDOW - 1));
    assign o_amp  = w_new_max ? i_data : r_amp;
    assign o_time = w_new_max ? i_time : r_time;

endmodule : v3_filter_ctrl_peak

// File: rtl/v3_filter_ctrl.sv
// ---------------------------------------------------------------------------
// v3_filter_ctrl
// Run controller for the v3 trapezoidal filter: drives the filter reset
// (clear, settle, soft re-clear), triggers on threshold crossings, searches a
// fixed window for the pulse peak and presents amplitude + timestamp on a
// valid/ready output. A dead time follows every window.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   enable          : run request (level)
//   soft_clear      : one-cycle request to re-initialise the filter
//   threshold       : unsigned trigger level
//   filt_data       : filter output sample
//   filt_reset      : active-low reset to the filter
//   ev_valid/ready  : event handshake
//   ev_amp, ev_time : peak amplitude and timestamp of the peak sample
//   busy            : high in CLEAR, SETTLE, PEAK, DEAD
//   drop_cnt        : events lost to backpressure, saturating
// ---------------------------------------------------------------------------
module v3_filter_ctrl
    import v3_filter_ctrl_parameters::*;
#(
    parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int PEAK_WINDOW   = DEF_PEAK_WINDOW,
    parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
    parameter int TS_WIDTH      = DEF_TS_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     soft_clear,
    input  logic [SIZE_ADC_DATA-1:0] threshold,
    input  logic [SIZE_ADC_DATA-1:0] filt_data,
    output logic                     filt_reset,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [SIZE_ADC_DATA-1:0] ev_amp,
    output logic [TS_WIDTH-1:0]      ev_time,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    // One counter serves CLEAR, SETTLE and DEAD, so size it for the longest.
    localparam int PH_W = $clog2(max_of3(CLEAR_CYCLES, SETTLE_CYCLES, DEAD_CYCLES));

    ctrl_state_t              r_state;
    ctrl_state_t              w_state_next;
    logic [PH_W-1:0]          r_phase_cnt;
    logic [PH_W-1:0]          w_phase_cnt_next;
    logic [TS_WIDTH-1:0]      r_ts;

    logic                     w_start;
    logic                     w_sample;
    logic                     w_issue;
    logic                     w_peak_done;
    logic [SIZE_ADC_DATA-1:0] w_peak_amp;
    logic [TS_WIDTH-1:0]      w_peak_time;

    logic                     r_ev_valid;
    logic [SIZE_ADC_DATA-1:0] r_ev_amp;
    logic [TS_WIDTH-1:0]      r_ev_time;
    logic [CNT_WIDTH-1:0]     r_drop_cnt;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    // FSM state and phase counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_phase_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_phase_cnt <= w_phase_cnt_next;
        end
    end

    // Next state. Dropping enable wins over everything, then soft_clear;
    // either one discards an open window simply by never raising w_issue.
    always_comb begin
        w_state_next     = r_state;
        w_phase_cnt_next = r_phase_cnt;
        w_start          = 1'b0;
        w_sample         = 1'b0;
        w_issue          = 1'b0;

        if (!enable) begin
            w_state_next = ST_IDLE;
        end else if (soft_clear && (r_state != ST_IDLE)) begin
            w_state_next     = ST_CLEAR;
            w_phase_cnt_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next     = ST_CLEAR;
                    w_phase_cnt_next = '0;
                end
                ST_CLEAR: begin
                    if (r_phase_cnt == PH_W'(CLEAR_CYCLES - 1)) begin
                        w_state_next     = ST_SETTLE;
                        w_phase_cnt_next = '0;
                    end else begin
                        w_phase_cnt_next = r_phase_cnt + PH_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (r_phase_cnt == PH_W'(SETTLE_CYCLES - 1)) begin
                        w_state_next     = ST_ARMED;
                        w_phase_cnt_next = '0;
                    end else begin
                        w_phase_cnt_next = r_phase_cnt + PH_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (filt_data > threshold) begin
                        w_start      = 1'b1;
                        w_state_next = ST_PEAK;
                    end
                end
                ST_PEAK: begin
                    w_sample = 1'b1;
                    if (w_peak_done) begin
                        w_issue          = 1'b1;
                        w_state_next     = ST_DEAD;
                        w_phase_cnt_next = '0;
                    end
                end
                ST_DEAD: begin
                    if (r_phase_cnt == PH_W'(DEAD_CYCLES - 1)) begin
                        w_state_next     = ST_ARMED;
                        w_phase_cnt_next = '0;
                    end else begin
                        w_phase_cnt_next = r_phase_cnt + PH_W'(1);
                    end
                end
                default: begin
                    w_state_next     = ST_IDLE;
                    w_phase_cnt_next = '0;
                end
            endcase
        end
    end

    v3_filter_ctrl_peak #(
        .DATA_W      (SIZE_ADC_DATA),
        .TS_W        (TS_WIDTH),
        .PEAK_WINDOW (PEAK_WINDOW)
    ) u_peak (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_start  (w_start),
        .i_sample (w_sample),
        .i_data   (filt_data),
        .i_time   (r_ts),
        .o_done   (w_peak_done),
        .o_amp    (w_peak_amp),
        .o_time   (w_peak_time)
    );

    // Output register runs independently of the FSM, so a pending event
    // survives enable going low and soft clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ev_valid <= 1'b0;
            r_ev_amp   <= '0;
            r_ev_time  <= '0;
            r_drop_cnt <= '0;
        end else if (w_issue) begin
            if (!r_ev_valid || ev_ready) begin
                r_ev_valid <= 1'b1;
                r_ev_amp   <= w_peak_amp;
                r_ev_time  <= w_peak_time;
            end else if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
        end else if (r_ev_valid && ev_ready) begin
            r_ev_valid <= 1'b0;
        end
    end

    assign filt_reset = (r_state == ST_SETTLE) || (r_state == ST_ARMED) ||
                        (r_state == ST_PEAK)   || (r_state == ST_DEAD);
    assign busy       = (r_state == ST_CLEAR)  || (r_state == ST_SETTLE) ||
                        (r_state == ST_PEAK)   || (r_state == ST_DEAD);
    assign ev_valid   = r_ev_valid;
    assign ev_amp     = r_ev_amp;
    assign ev_time    = r_ev_time;
    assign drop_cnt   = r_drop_cnt;

endmodule : v3_filter_ctrl
